// File: rtl/life_pkg.sv
// Shared types and constants for the Life grid display path.
package life_pkg;

    typedef logic [63:0] grid_t;
    typedef logic [7:0]  row_t;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    localparam int unsigned GRID_ROWS = 8;

    // Row r of a grid occupies bits [8r+7:8r]; column c is bit 8r+c.
    function automatic row_t grid_row(input grid_t g, input logic [2:0] r);
        return g[{r, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that pulses expire in the last cycle of a loaded interval.
module scan_timer #(
    parameter int unsigned Width = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             expire
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load wins over counting; the count parks at zero once the interval is spent.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N gives N cycles, the Nth of which sees expire.
    assign expire = (cnt_q == Width'(1));

endmodule

// File: rtl/life_matrix_scan.sv
// Row-multiplexed 8x8 LED driver with double-buffered generations and a
// frame-count step request back to the evolution datapath.
module life_matrix_scan
    import life_pkg::*;
#(
    parameter int unsigned ROW_CYCLES     = 1024,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned FRAMES_PER_GEN = 30
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  enable,
    input  grid_t grid_in,
    input  logic  grid_valid,
    output row_t  row_sel,
    output row_t  col_data,
    output logic  frame_done,
    output logic  gen_step
);

    localparam int unsigned MaxCycles = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
    localparam int unsigned FcntW     = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    scan_state_t      state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [FcntW-1:0] frame_cnt_q, frame_cnt_d;
    grid_t            pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    grid_t            display_q, display_d;
    row_t             row_sel_q, row_sel_d;
    row_t             col_data_q, col_data_d;
    logic             frame_done_q, frame_done_d;
    logic             gen_step_q, gen_step_d;

    logic              timer_load;
    logic [TimerW-1:0] timer_load_val;
    logic              timer_expire;

    scan_timer #(
        .Width (TimerW)
    ) u_scan_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .expire   (timer_expire)
    );

    // Scan FSM next state, buffer swaps and registered output values.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        frame_cnt_d    = frame_cnt_q;
        pending_d      = pending_q;
        pend_vld_d     = pend_vld_q;
        display_d      = display_q;
        frame_done_d   = 1'b0;
        gen_step_d     = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;

        unique case (state_q)
            SCAN_IDLE: begin
                if (enable) begin
                    display_d      = pending_q;
                    pend_vld_d     = 1'b0;
                    row_d          = '0;
                    frame_cnt_d    = '0;
                    timer_load     = 1'b1;
                    timer_load_val = TimerW'(BLANK_CYCLES);
                    state_d        = SCAN_BLANK;
                end
            end
            SCAN_BLANK: begin
                if (!enable) begin
                    row_d       = '0;
                    frame_cnt_d = '0;
                    timer_load  = 1'b1;
                    state_d     = SCAN_IDLE;
                end else if (timer_expire) begin
                    timer_load     = 1'b1;
                    timer_load_val = TimerW'(ROW_CYCLES);
                    state_d        = SCAN_DRIVE;
                end
            end
            SCAN_DRIVE: begin
                if (!enable) begin
                    row_d       = '0;
                    frame_cnt_d = '0;
                    timer_load  = 1'b1;
                    state_d     = SCAN_IDLE;
                end else if (timer_expire) begin
                    timer_load     = 1'b1;
                    timer_load_val = TimerW'(BLANK_CYCLES);
                    state_d        = SCAN_BLANK;
                    if (row_q != 3'(GRID_ROWS - 1)) begin
                        row_d = row_q + 3'd1;
                    end else begin
                        // Frame boundary: the only point where the shown grid may change.
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        if (pend_vld_q) begin
                            display_d  = pending_q;
                            pend_vld_d = 1'b0;
                        end
                        if (frame_cnt_q == FcntW'(FRAMES_PER_GEN - 1)) begin
                            gen_step_d  = 1'b1;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FcntW'(1);
                        end
                    end
                end
            end
            default: state_d = SCAN_IDLE;
        endcase

        // Capture after any swap so a strobe on the swap edge stays pending.
        if (grid_valid) begin
            pending_d  = grid_in;
            pend_vld_d = 1'b1;
        end

        // Outputs follow the next state so they line up with it cycle for cycle.
        if (state_d == SCAN_DRIVE) begin
            row_sel_d  = row_t'(1) << row_d;
            col_data_d = grid_row(display_d, row_d);
        end else begin
            row_sel_d  = '0;
            col_data_d = '0;
        end
    end

    // State, buffers and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SCAN_IDLE;
            row_q        <= '0;
            frame_cnt_q  <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            display_q    <= '0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
            gen_step_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            frame_cnt_q  <= frame_cnt_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            display_q    <= display_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            gen_step_q   <= gen_step_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign gen_step   = gen_step_q;

endmodule
